// File: rtl/iram_load_arbiter_if.sv
// Byte-serial program loader link: the loader is the master and the arbiter is the slave.
interface iram_load_arbiter_if;
   logic       ld_start;
   logic       ld_abort;
   logic       ld_valid;
   logic [7:0] ld_byte;
   logic       ld_ready;
   logic       ld_done;

   modport master (
      output ld_start, ld_abort, ld_valid, ld_byte,
      input  ld_ready, ld_done
   );

   modport slave (
      input  ld_start, ld_abort, ld_valid, ld_byte,
      output ld_ready, ld_done
   );
endinterface

// File: rtl/iram_load_arbiter.sv
// Shares the single IRAM port between CPU fetch and a byte-serial program loader.
// A load halts the CPU, writes words 0..WORDS-1 in order, then pulses a PC restart.
module iram_load_arbiter #(
   parameter int unsigned WORDS = 128,
   parameter int unsigned AW    = 7
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [7:0]            cpu_addr,
   output logic [15:0]           cpu_instr,
   output logic                  cpu_halt,
   output logic                  cpu_restart,
   iram_load_arbiter_if.slave    ld,
   output logic [AW-1:0]         mem_addr,
   output logic                  mem_we,
   output logic [15:0]           mem_wdata,
   input  logic [15:0]           mem_rdata
);

   typedef enum logic [2:0] {RUN, LOAD_LO, LOAD_HI, WRITE, DONE} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] counter, counter_nxt;
   logic [7:0]    lo_byte, lo_nxt;
   logic [7:0]    hi_byte, hi_nxt;
   logic          unused_addr_lsb;

   // CPU addresses bytes; bit 0 never selects anything in a 16-bit IRAM.
   assign unused_addr_lsb = cpu_addr[0];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= RUN;
         counter <= '0;
         lo_byte <= '0;
         hi_byte <= '0;
      end else begin
         state   <= state_nxt;
         counter <= counter_nxt;
         lo_byte <= lo_nxt;
         hi_byte <= hi_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      counter_nxt = counter;
      lo_nxt      = lo_byte;
      hi_nxt      = hi_byte;
      cpu_halt    = 1'b1;
      cpu_restart = 1'b0;
      cpu_instr   = '0;
      ld.ld_ready = 1'b0;
      ld.ld_done  = 1'b0;
      mem_addr    = counter;
      mem_we      = 1'b0;
      mem_wdata   = {hi_byte, lo_byte};

      unique case (state)
         RUN: begin
            cpu_halt  = 1'b0;
            mem_addr  = cpu_addr[AW:1];
            cpu_instr = mem_rdata;
            if (ld.ld_start) begin
               state_nxt   = LOAD_LO;
               counter_nxt = '0;
            end
         end
         LOAD_LO: begin
            ld.ld_ready = 1'b1;
            if (ld.ld_abort) begin
               state_nxt = RUN;
            end else if (ld.ld_valid) begin
               lo_nxt    = ld.ld_byte;
               state_nxt = LOAD_HI;
            end
         end
         LOAD_HI: begin
            ld.ld_ready = 1'b1;
            if (ld.ld_abort) begin
               state_nxt = RUN;
            end else if (ld.ld_valid) begin
               hi_nxt    = ld.ld_byte;
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            // Abort suppresses the write of the word currently being committed.
            if (ld.ld_abort) begin
               state_nxt = RUN;
            end else begin
               mem_we = 1'b1;
               if (counter == AW'(WORDS - 1)) begin
                  state_nxt = DONE;
               end else begin
                  counter_nxt = counter + 1'b1;
                  state_nxt   = LOAD_LO;
               end
            end
         end
         DONE: begin
            ld.ld_done  = 1'b1;
            cpu_restart = 1'b1;
            state_nxt   = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

endmodule

// File: tb/tb_iram_load_arbiter.sv
// Scoreboard bench: stimulus queues expected IRAM writes and done pulses, a negedge monitor checks them.
module tb_iram_load_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [7:0]  cpu_addr;
   logic [15:0] cpu_instr;
   logic        cpu_halt;
   logic        cpu_restart;
   logic [6:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   iram_load_arbiter_if lif ();

   iram_load_arbiter #(.WORDS(128), .AW(7)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .cpu_addr    (cpu_addr),
      .cpu_instr   (cpu_instr),
      .cpu_halt    (cpu_halt),
      .cpu_restart (cpu_restart),
      .ld          (lif),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 CLK = ~CLK;

   // Fixed read pattern: word 3 holds 16'h0F01, every other word reads its own index.
   assign mem_rdata = (mem_addr == 7'd3) ? 16'h0F01 : {9'h000, mem_addr};

   int unsigned cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [22:0] exp_wr[$];
   int unsigned exp_done[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor
   always @(negedge CLK) begin
      if (!RESET) begin
         if (mem_we) begin
            if (exp_wr.size() == 0) begin
               chk("unexpected_write", {25'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
               logic [22:0] e;
               e = exp_wr.pop_front();
               chk("write_addr", {25'h0, mem_addr}, {25'h0, e[22:16]});
               chk("write_data", {16'h0, mem_wdata}, {16'h0, e[15:0]});
            end
         end
         if (ld_done_seen()) begin
            if (exp_done.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               int unsigned ec;
               ec = exp_done.pop_front();
               chk("done_cycle", cyc, ec);
               chk("done_restart", {31'h0, cpu_restart}, 32'd1);
               chk("done_halt", {31'h0, cpu_halt}, 32'd1);
            end
         end else if (cpu_restart) begin
            chk("restart_without_done", 32'd1, 32'd0);
         end
      end
   end

   function automatic logic ld_done_seen();
      return lif.ld_done;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      int unsigned n;
      if (gap > 0) begin
         lif.ld_valid = 1'b0;
         lif.ld_byte  = 8'hEE;
         repeat (gap) tick();
      end
      lif.ld_valid = 1'b1;
      lif.ld_byte  = b;
      n = 0;
      forever begin
         @(negedge CLK);
         if (lif.ld_ready) break;
         n++;
         if (n > 20) begin
            chk("byte_accept_timeout", 32'd1, 32'd0);
            lif.ld_valid = 1'b0;
            return;
         end
      end
      tick();
      if (gap > 0) lif.ld_valid = 1'b0;
   endtask

   task automatic send_word(input logic [6:0] a, input logic [15:0] d, input int unsigned gap);
      exp_wr.push_back({a, d});
      send_byte(d[7:0], gap);
      send_byte(d[15:8], gap);
   endtask

   task automatic start_load(input logic with_abort, output int unsigned start_cyc);
      lif.ld_start = 1'b1;
      lif.ld_abort = with_abort;
      tick();
      lif.ld_start = 1'b0;
      lif.ld_abort = 1'b0;
      start_cyc    = cyc;
   endtask

   initial begin
      int unsigned sc;
      RESET        = 1'b1;
      cpu_addr     = 8'h00;
      lif.ld_start = 1'b0;
      lif.ld_abort = 1'b0;
      lif.ld_valid = 1'b0;
      lif.ld_byte  = 8'h00;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_halt", {31'h0, cpu_halt}, 32'd0);
      chk("rst_restart", {31'h0, cpu_restart}, 32'd0);
      chk("rst_ready", {31'h0, lif.ld_ready}, 32'd0);
      chk("rst_done", {31'h0, lif.ld_done}, 32'd0);
      chk("rst_we", {31'h0, mem_we}, 32'd0);
      chk("rst_wdata", {16'h0, mem_wdata}, 32'd0);
      tick();
      RESET = 1'b0;

      // RUN fetch, zero latency
      cpu_addr = 8'h06;
      @(negedge CLK);
      chk("run_addr", {25'h0, mem_addr}, 32'd3);
      chk("run_instr", {16'h0, cpu_instr}, 32'h0F01);
      chk("run_halt", {31'h0, cpu_halt}, 32'd0);
      cpu_addr = 8'h11;
      @(negedge CLK);
      chk("run_addr2", {25'h0, mem_addr}, 32'd8);
      chk("run_instr2", {16'h0, cpu_instr}, 32'h0008);
      tick();

      // Full load, valid held high; word 0 is bytes 01,F0
      start_load(1'b0, sc);
      exp_done.push_back(sc + 384);
      for (int unsigned k = 0; k < 128; k++) begin
         logic [7:0] kb;
         kb = 8'(k);
         send_word(7'(k), (k == 0) ? 16'hF001 : {kb ^ 8'hA5, kb}, 0);
      end
      lif.ld_valid = 1'b0;
      begin
         int unsigned n;
         n = 0;
         while (!lif.ld_done && n < 10) begin
            @(negedge CLK);
            n++;
         end
         chk("full_done_seen", {31'h0, lif.ld_done}, 32'd1);
      end
      @(negedge CLK);
      chk("post_done_halt", {31'h0, cpu_halt}, 32'd0);
      chk("post_done_restart", {31'h0, cpu_restart}, 32'd0);
      tick();

      // Abort in WRITE of word 5
      start_load(1'b0, sc);
      for (int unsigned k = 0; k < 5; k++) send_word(7'(k), 16'h1100 + 16'(k), 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      lif.ld_valid = 1'b0;
      lif.ld_abort = 1'b1;
      @(negedge CLK);
      chk("abort_we", {31'h0, mem_we}, 32'd0);
      chk("abort_addr", {25'h0, mem_addr}, 32'd5);
      chk("halted_instr", {16'h0, cpu_instr}, 32'd0);
      chk("halted_halt", {31'h0, cpu_halt}, 32'd1);
      tick();
      lif.ld_abort = 1'b0;
      @(negedge CLK);
      chk("abort_run_halt", {31'h0, cpu_halt}, 32'd0);
      chk("abort_no_done", {31'h0, lif.ld_done}, 32'd0);
      chk("abort_run_addr", {25'h0, mem_addr}, 32'd8);
      tick();

      // Start with abort in RUN (start wins), then gapped valid
      start_load(1'b1, sc);
      @(negedge CLK);
      chk("start_wins_halt", {31'h0, cpu_halt}, 32'd1);
      chk("start_wins_ready", {31'h0, lif.ld_ready}, 32'd1);
      tick();
      send_word(7'd0, 16'h5AC3, 3);
      send_word(7'd1, 16'h9E27, 3);
      tick();
      lif.ld_abort = 1'b1;
      tick();
      lif.ld_abort = 1'b0;
      @(negedge CLK);
      chk("gap_abort_halt", {31'h0, cpu_halt}, 32'd0);
      tick();

      // RESET in LOAD_HI
      start_load(1'b0, sc);
      send_byte(8'h77, 0);
      lif.ld_valid = 1'b0;
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      @(negedge CLK);
      chk("rst_mid_halt", {31'h0, cpu_halt}, 32'd0);
      chk("rst_mid_we", {31'h0, mem_we}, 32'd0);
      chk("rst_mid_ready", {31'h0, lif.ld_ready}, 32'd0);
      chk("rst_mid_wdata", {16'h0, mem_wdata}, 32'd0);
      tick();
      start_load(1'b0, sc);
      send_word(7'd0, 16'h1234, 0);
      lif.ld_valid = 1'b0;
      tick();
      lif.ld_abort = 1'b1;
      tick();
      lif.ld_abort = 1'b0;
      repeat (3) tick();

      chk("writes_outstanding", exp_wr.size(), 32'd0);
      chk("done_outstanding", exp_done.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
